// File: rtl/vie_sram_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// vie_sram_arbiter_pkg : shared owner encoding, tag entry and defaults
// Revision 1.0
// ==========================================================================
package vie_sram_arbiter_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int TAG_W          = 2;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_MAX_STARVE = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  // Loads and ungranted cycles must never write the array.
  function automatic logic [3:0] store_wen(input logic       grant,
                                           input logic       wr,
                                           input logic [3:0] wstrb);
    return (grant && wr) ? wstrb : 4'b0000;
  endfunction

endpackage : vie_sram_arbiter_pkg
`default_nettype wire

// File: rtl/vie_sram_arbiter_if.sv
`default_nettype none
// ==========================================================================
// vie_sram_arbiter_if : fetch, load/store and SRAM buses of the arbiter
// Revision 1.0
// ==========================================================================
interface vie_sram_arbiter_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  // Arbiter side.
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  // Requesters plus SRAM side.
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface : vie_sram_arbiter_if
`default_nettype wire

// File: rtl/vie_lat_tagpipe.sv
`default_nettype none
// ==========================================================================
// vie_lat_tagpipe : RD_LAT-stage {valid, owner} shift register
// Revision 1.0
// ==========================================================================
module vie_lat_tagpipe
  import vie_sram_arbiter_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic clock,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  logic [RD_LAT-1:0][TAG_W-1:0] pipe_q;
  logic [RD_LAT-1:0][TAG_W-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[RD_LAT-1];

endmodule : vie_lat_tagpipe
`default_nettype wire

// File: rtl/vie_sram_arbiter.sv
`default_nettype none
// ==========================================================================
// vie_sram_arbiter : fetch/data sharing of one single-port SRAM
// Revision 1.0
// ==========================================================================
module vie_sram_arbiter
  import vie_sram_arbiter_pkg::*;
#(
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input logic               clock,
  input logic               reset,
  vie_sram_arbiter_if.slave bus
);

  localparam int               CNT_W        = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             grant_inst;
  logic             grant_data;
  tag_t             tag_in;
  tag_t             tag_out;
  logic             resp_valid;

  // Data wins ties unless fetch has already waited MAX_STARVE grants.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (reset) begin
      if (bus.data_req && bus.inst_req) begin
        if (starve_cnt_q == STARVE_LIMIT) begin
          grant_inst = 1'b1;
        end else begin
          grant_data = 1'b1;
        end
      end else if (bus.data_req) begin
        grant_data = 1'b1;
      end else if (bus.inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.inst_req || grant_inst) begin
      starve_cnt_d = '0;
    end else if (grant_data && (starve_cnt_q != STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    bus.sram_en      = grant_inst | grant_data;
    bus.sram_wen     = store_wen(grant_data, bus.data_wr, bus.data_wstrb);
    bus.sram_wdata   = grant_data ? bus.data_wdata : 32'h0;
    bus.sram_addr    = 32'h0;
    if (grant_data) begin
      bus.sram_addr = bus.data_addr;
    end else if (grant_inst) begin
      bus.sram_addr = bus.inst_addr;
    end
    bus.inst_addr_ok = grant_inst;
    bus.data_addr_ok = grant_data;
  end

  always_comb begin
    tag_in.valid = grant_inst | grant_data;
    tag_in.owner = grant_data ? OWN_DATA : OWN_INST;
  end

  vie_lat_tagpipe #(
    .RD_LAT (RD_LAT)
  ) u_tagpipe (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Gating by reset keeps pre-reset tags from completing in the reset cycle.
  assign resp_valid = tag_out.valid & reset;

  always_comb begin
    bus.inst_data_ok = resp_valid && (tag_out.owner == OWN_INST);
    bus.data_data_ok = resp_valid && (tag_out.owner == OWN_DATA);
    bus.inst_rdata   = bus.inst_data_ok ? bus.sram_rdata : 32'h0;
    bus.data_rdata   = bus.data_data_ok ? bus.sram_rdata : 32'h0;
  end

endmodule : vie_sram_arbiter
`default_nettype wire

// File: tb/tb_vie_sram_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_vie_sram_arbiter : directed checks on RD_LAT=1 and RD_LAT=3 instances
// Revision 1.0
// ==========================================================================
module tb_vie_sram_arbiter;

  localparam logic [31:0] SCRAMBLE = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic reset1;
  logic reset3;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   resp_cnt = 0;

  always #5 clk = ~clk;

  vie_sram_arbiter_if bus1 ();
  vie_sram_arbiter_if bus3 ();

  vie_sram_arbiter #(.RD_LAT(1), .MAX_STARVE(4)) dut1 (
    .clock (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  vie_sram_arbiter #(.RD_LAT(3), .MAX_STARVE(4)) dut3 (
    .clock (clk),
    .reset (reset3),
    .bus   (bus3)
  );

  // Contents of words never written.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h3C1D_0001;
      32'h0000_1000: return 32'h1122_3344;
      default:       return a ^ SCRAMBLE;
    endcase
  endfunction

  // RD_LAT=1 SRAM with byte writes; read returns pre-write contents.
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] rd1;
  logic [31:0] cur1;
  always @(posedge clk) begin
    if (bus1.sram_en) begin
      cur1 = mem1.exists(bus1.sram_addr) ? mem1[bus1.sram_addr] : init_word(bus1.sram_addr);
      rd1 <= cur1;
      for (int b = 0; b < 4; b++) begin
        if (bus1.sram_wen[b]) cur1[8*b +: 8] = bus1.sram_wdata[8*b +: 8];
      end
      if (bus1.sram_wen != 4'b0) mem1[bus1.sram_addr] = cur1;
    end
  end
  assign bus1.sram_rdata = rd1;

  // RD_LAT=3 read-only SRAM returning a function of the address.
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= bus3.sram_en ? (bus3.sram_addr ^ SCRAMBLE) : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.sram_rdata = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  logic [9:0]  fair_pat;
  logic [31:0] lat_addr [50];
  logic        lat_data [50];

  initial begin
    bus1.inst_req = 1'b1; bus1.inst_addr = 32'hBFC0_0000;
    bus1.data_req = 1'b1; bus1.data_wr = 1'b0; bus1.data_wstrb = 4'b0;
    bus1.data_addr = 32'h0000_2000; bus1.data_wdata = 32'h0;
    bus3.inst_req = 1'b0; bus3.inst_addr = 32'h0;
    bus3.data_req = 1'b0; bus3.data_wr = 1'b0; bus3.data_wstrb = 4'b0;
    bus3.data_addr = 32'h0; bus3.data_wdata = 32'h0;
    reset1 = 1'b0;
    reset3 = 1'b0;

    // Reset held with both requests pending.
    for (int k = 0; k < 3; k++) begin
      to_sample();
      chkb($sformatf("rst%0d sram_en", k), bus1.sram_en, 1'b0);
      chkb($sformatf("rst%0d inst_addr_ok", k), bus1.inst_addr_ok, 1'b0);
      chkb($sformatf("rst%0d data_addr_ok", k), bus1.data_addr_ok, 1'b0);
      chkb($sformatf("rst%0d data_ok", k), bus1.inst_data_ok | bus1.data_data_ok, 1'b0);
      chk($sformatf("rst%0d sram_wen", k), {28'h0, bus1.sram_wen}, 32'h0);
      if (k < 2) to_drive();
    end
    to_drive();
    reset1 = 1'b1;
    reset3 = 1'b1;
    to_sample();
    chkb("rel data_addr_ok", bus1.data_addr_ok, 1'b1);
    chkb("rel inst_addr_ok", bus1.inst_addr_ok, 1'b0);
    chk("rel sram_addr", bus1.sram_addr, 32'h0000_2000);
    to_drive();
    bus1.inst_req = 1'b0;
    bus1.data_req = 1'b0;
    to_sample();
    chkb("rel data_data_ok", bus1.data_data_ok, 1'b1);
    chkb("rel inst_data_ok", bus1.inst_data_ok, 1'b0);

    // Lone fetch.
    to_drive();
    bus1.inst_req = 1'b1;
    to_sample();
    chkb("fetch sram_en", bus1.sram_en, 1'b1);
    chk("fetch sram_addr", bus1.sram_addr, 32'hBFC0_0000);
    chkb("fetch inst_addr_ok", bus1.inst_addr_ok, 1'b1);
    chkb("fetch data_addr_ok", bus1.data_addr_ok, 1'b0);
    chk("fetch sram_wen", {28'h0, bus1.sram_wen}, 32'h0);
    to_drive();
    bus1.inst_req = 1'b0;
    to_sample();
    chkb("fetch inst_data_ok", bus1.inst_data_ok, 1'b1);
    chk("fetch inst_rdata", bus1.inst_rdata, 32'h3C1D_0001);
    chkb("fetch data_data_ok", bus1.data_data_ok, 1'b0);
    chkb("idle sram_en", bus1.sram_en, 1'b0);

    // Half-word store then load of the same word.
    to_drive();
    bus1.data_req = 1'b1; bus1.data_wr = 1'b1; bus1.data_wstrb = 4'b0011;
    bus1.data_addr = 32'h0000_1000; bus1.data_wdata = 32'hDEAD_BEEF;
    to_sample();
    chk("store sram_wen", {28'h0, bus1.sram_wen}, 32'h3);
    chk("store sram_wdata", bus1.sram_wdata, 32'hDEAD_BEEF);
    chkb("store data_addr_ok", bus1.data_addr_ok, 1'b1);
    to_drive();
    bus1.data_wr = 1'b0;
    to_sample();
    chk("load sram_wen", {28'h0, bus1.sram_wen}, 32'h0);
    chkb("store data_data_ok", bus1.data_data_ok, 1'b1);
    to_drive();
    bus1.data_req = 1'b0;
    to_sample();
    chkb("load data_data_ok", bus1.data_data_ok, 1'b1);
    chk("load data_rdata", bus1.data_rdata, 32'h1122_BEEF);
    chkb("load inst_data_ok", bus1.inst_data_ok, 1'b0);

    // Fairness: bit k set means data is granted in cycle k.
    fair_pat = 10'b01111_01111;
    for (int k = 0; k <= 10; k++) begin
      to_drive();
      bus1.inst_req = (k < 10);
      bus1.data_req = (k < 10);
      to_sample();
      if (k < 10) begin
        chkb($sformatf("fair%0d data_addr_ok", k), bus1.data_addr_ok, fair_pat[k]);
        chkb($sformatf("fair%0d inst_addr_ok", k), bus1.inst_addr_ok, ~fair_pat[k]);
      end
      if (k > 0) begin
        chkb($sformatf("fair%0d data_data_ok", k), bus1.data_data_ok, fair_pat[k-1]);
        chkb($sformatf("fair%0d inst_data_ok", k), bus1.inst_data_ok, ~fair_pat[k-1]);
        if (!fair_pat[k-1]) chk($sformatf("fair%0d inst_rdata", k), bus1.inst_rdata, 32'h3C1D_0001);
      end
    end

    // RD_LAT=3 alternating fetch/data, one accept per cycle.
    for (int i = 0; i < 50; i++) begin
      lat_data[i] = i[0];
      lat_addr[i] = lat_data[i] ? (32'h0000_8000 + 32'(4 * i)) : (32'h0000_0100 + 32'(4 * i));
    end
    for (int i = 0; i < 55; i++) begin
      to_drive();
      bus3.inst_req  = (i < 50) && !lat_data[i % 50];
      bus3.data_req  = (i < 50) && lat_data[i % 50];
      bus3.inst_addr = lat_addr[i % 50];
      bus3.data_addr = lat_addr[i % 50];
      to_sample();
      resp_cnt += int'(bus3.inst_data_ok) + int'(bus3.data_data_ok);
      if (i < 50) begin
        chkb($sformatf("lat%0d addr_ok", i),
             lat_data[i] ? bus3.data_addr_ok : bus3.inst_addr_ok, 1'b1);
      end
      if (i >= 3 && i < 53) begin
        chkb($sformatf("lat%0d data_data_ok", i), bus3.data_data_ok, lat_data[i-3]);
        chkb($sformatf("lat%0d inst_data_ok", i), bus3.inst_data_ok, ~lat_data[i-3]);
        chk($sformatf("lat%0d rdata", i),
            lat_data[i-3] ? bus3.data_rdata : bus3.inst_rdata, lat_addr[i-3] ^ SCRAMBLE);
      end else begin
        chkb($sformatf("lat%0d quiet", i), bus3.inst_data_ok | bus3.data_data_ok, 1'b0);
      end
    end
    chk("lat response count", 32'(resp_cnt), 32'd50);

    // Reset with three responses outstanding.
    to_drive();
    bus3.inst_req = 1'b1; bus3.inst_addr = 32'h0000_0040;
    to_sample();
    chkb("mid req0 inst_addr_ok", bus3.inst_addr_ok, 1'b1);
    to_drive();
    bus3.inst_req = 1'b0; bus3.data_req = 1'b1; bus3.data_addr = 32'h0000_0044;
    to_sample();
    chkb("mid req1 data_addr_ok", bus3.data_addr_ok, 1'b1);
    to_drive();
    bus3.data_req = 1'b0; bus3.inst_req = 1'b1; bus3.inst_addr = 32'h0000_0048;
    to_sample();
    chkb("mid req2 inst_addr_ok", bus3.inst_addr_ok, 1'b1);
    to_drive();
    bus3.inst_req = 1'b0;
    reset3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      to_sample();
      chkb($sformatf("mid%0d inst_data_ok", k), bus3.inst_data_ok, 1'b0);
      chkb($sformatf("mid%0d data_data_ok", k), bus3.data_data_ok, 1'b0);
      to_drive();
      reset3 = 1'b1;
    end
    bus3.data_req = 1'b1; bus3.data_addr = 32'h0000_004C;
    to_sample();
    chkb("post data_addr_ok", bus3.data_addr_ok, 1'b1);
    for (int k = 0; k < 3; k++) begin
      to_drive();
      bus3.data_req = 1'b0;
      to_sample();
    end
    chkb("post data_data_ok", bus3.data_data_ok, 1'b1);
    chk("post data_rdata", bus3.data_rdata, 32'h0000_004C ^ SCRAMBLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_vie_sram_arbiter
`default_nettype wire
